commit_write_scheduler: RTL and testbench
=========================================

# commit_write_scheduler

Sits between a dual-commit ROB and the register file's single commit write port. Accepts zero, one or two in-order commits per cycle into a small FIFO, then drains exactly one per cycle to the register file commit inputs (enable/index/rename/value). Applies backpressure to the ROB, discards writes to x0, and holds the drain during mispredict-flush cycles so no architectural write is lost.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk
- rdy  in  1  global ready; low freezes all state and outputs
- jump_wrong  in  1  mispredict flush, same signal the register file sees
- c0_valid, c1_valid  in  1 each  commit slot valid; slot 0 is older than slot 1
- c0_index, c1_index  in  `REGINDEX  destination register
- c0_rename, c1_rename  in  `ROBINDEX  ROB tag of the committing instruction
- c0_value, c1_value  in  `DATALEN  result value
- commit_ready  out  1  ROB may present commits this cycle
- rf_enable  out  1  drives register file rob_enable
- rf_index  out  `REGINDEX  drives rob_commit_index
- rf_rename  out  `ROBINDEX  drives rob_commit_rename
- rf_value  out  `DATALEN  drives rob_commit_value
- fifo_count  out  log2(DEPTH)+1  occupancy, debug/perf

## Operation
- Storage: DEPTH entries of {index, rename, value}, head and tail pointers with wrap at DEPTH, plus a count register.
- Enqueue filter: a slot is kept only if valid and index ≠ 0. Kept slots are written in order (slot 0 at tail, slot 1 at tail+1, or slot 1 at tail if slot 0 was dropped). Tail and count advance by the number kept (0/1/2).
- c1_valid with c0_valid low is legal; treat slot 1 as the only commit.
- commit_ready = (count ≤ DEPTH−2), computed from the registered count only. Same-cycle dequeue is not credited. The ROB must not assert any cN_valid while commit_ready is low. Enqueue presented while not ready is dropped; this is a protocol violation that the bench flags.
- Drain: a cycle is a drain cycle when rdy=1, jump_wrong=0 and count ≠ 0 (count ≠ 1 if that entry is already being presented). In a drain cycle the head entry is loaded into rf_* with rf_enable=1, head advances, and count decrements.
- Output register: rf_* are registered. A presented entry counts as consumed at the end of the cycle in which it is shown with rdy=1 and jump_wrong=0. If rdy=0 or jump_wrong=1, rf_* hold unchanged and are re-presented next cycle, because the register file ignores its commit inputs in those cycles.
- When nothing is eligible after consumption, rf_enable drops to 0. rf_index, rf_rename and rf_value keep their last values.
- jump_wrong never discards FIFO contents. Committed results are architectural. Enqueue is still accepted in a jump_wrong cycle.
- Simultaneous enqueue of 2 and dequeue of 1 in the same cycle: count increases by 1.
- rdy=0: no enqueue, no dequeue, all registers hold. The ROB is also frozen by rdy.

## Timing
- Reset (rst=0 at edge): head=tail=count=0, rf_enable=0, rf_index=0, rf_rename=`ROBNOTRENAME, rf_value=0. commit_ready=1 from the first cycle after reset.
- Latency: a commit enqueued into an empty FIFO at edge N appears on rf_* after edge N+1. rf_enable is high during cycle N+1.
- Throughput: 1 register-file write per cycle sustained.
- Ordering: register-file writes appear strictly in program order (slot 0 before slot 1, earlier cycles first).
- Reset mid-operation discards all entries; no partial write is emitted.

## Structure
- Use `REGINDEX, `ROBINDEX, `DATALEN, `ROBNOTRENAME, `TRUE/`FALSE from the shared define.v. Add `COMMITFIFODEPTH there.
- One sub-module: commit_fifo, a 2-write/1-read circular buffer with count. The top level holds the filter, ready logic and output register.

## Test plan
- Single commit {x5, tag 3, 0xDEADBEEF} into empty FIFO -> rf_enable=1 one cycle later with those values, then rf_enable=0.
- Pair {x1,tag1,0x11},{x2,tag2,0x22} every cycle for 8 cycles -> commit_ready drops once count reaches 3; writes emerge x1,x2,x1,x2… in order with no loss or duplication.
- Pair with c0_index=0 and c1={x7,tag4,0x77} -> only x7 written; count +1.
- Entry presented while jump_wrong=1 for 2 cycles -> rf_* held for both cycles and consumed on the first cycle with jump_wrong=0; no entry is skipped.
- rdy=0 for 3 cycles with 2 entries queued -> fifo_count and rf_* frozen; draining resumes in order once rdy returns.
- rst=0 with 3 entries queued -> next cycle rf_enable=0, fifo_count=0, commit_ready=1.

Source files
------------

// File: rtl/commit_write_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// commit_write_scheduler_pkg
//
// Purpose: shared types and helpers for the commit write scheduler, which
// funnels up to two in-order ROB commits per cycle into the register file's
// single commit write port.
//
// Also carries the core-wide width macros. They are guarded so that the
// project define.v takes precedence whenever it is compiled first.
//
// Contents:
//   COMMIT_FIFO_DEPTH  default FIFO depth (power of two, >= 2)
//   commit_entry_t     one queued architectural write {index, rename, value}
//   ENTRY_RESET        value the register-file-facing outputs take on reset
//   push_num_e         number of commits kept in a cycle (0/1/2)
//   slot_kept()        a commit slot is kept only if valid and not x0
//   kept_count()       how many of the two slots were kept
// ---------------------------------------------------------------------------

`ifndef REGINDEX
`define REGINDEX 4:0
`endif
`ifndef ROBINDEX
`define ROBINDEX 4:0
`endif
`ifndef DATALEN
`define DATALEN 31:0
`endif
`ifndef ROBNOTRENAME
`define ROBNOTRENAME 5'b10000
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif
`ifndef COMMITFIFODEPTH
`define COMMITFIFODEPTH 4
`endif

package commit_write_scheduler_pkg;

  localparam int COMMIT_FIFO_DEPTH = `COMMITFIFODEPTH;

  // One architectural register write waiting for the commit port
  typedef struct packed {
    logic [`REGINDEX] index;
    logic [`ROBINDEX] rename;
    logic [`DATALEN]  value;
  } commit_entry_t;

  // Register-file-facing outputs after reset: no register, not renamed
  localparam commit_entry_t ENTRY_RESET = '{
    index:  '0,
    rename: `ROBNOTRENAME,
    value:  '0
  };

  // How many commit slots get written into the FIFO this cycle
  typedef enum logic [1:0] {
    PUSH_NONE = 2'd0,
    PUSH_ONE  = 2'd1,
    PUSH_TWO  = 2'd2
  } push_num_e;

  // Writes to x0 are architecturally invisible, so they never take a slot
  function automatic logic slot_kept(input logic valid,
                                     input logic [`REGINDEX] index);
    return valid && (index != '0);
  endfunction

  function automatic push_num_e kept_count(input logic keep0,
                                           input logic keep1);
    case ({keep0, keep1})
      2'b11:   return PUSH_TWO;
      2'b00:   return PUSH_NONE;
      default: return PUSH_ONE;
    endcase
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// ---------------------------------------------------------------------------
// commit_fifo
//
// Purpose: circular buffer of commit_entry_t with two write ports and one
// read port. Writes are pre-compacted by the caller: push_a always lands at
// the tail and push_b at tail+1, so program order is kept by construction.
// The caller guarantees it never pushes past DEPTH and never pops when empty.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         synchronous active-low reset (empties the buffer)
//   push_num    number of entries to write this cycle (0/1/2)
//   push_a      entry written at the tail
//   push_b      entry written at tail+1 (only when push_num is PUSH_TWO)
//   pop         remove the head entry this cycle
//   head_entry  current head entry (combinational read)
//   count       current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------

module commit_fifo
  import commit_write_scheduler_pkg::*;
#(
  parameter  int DEPTH = COMMIT_FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  push_num_e     push_num,
  input  commit_entry_t push_a,
  input  commit_entry_t push_b,
  input  logic          pop,
  output commit_entry_t head_entry,
  output logic [CW-1:0] count
);

  commit_entry_t mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  assign head_entry = mem[head_ptr];

  // Storage array: no reset needed, the pointers and count decide what is
  // valid. Slot b goes one past slot a; the pointer width gives the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (push_num != PUSH_NONE) begin
        mem[tail_ptr] <= push_a;
      end
      if (push_num == PUSH_TWO) begin
        mem[tail_ptr + PW'(1)] <= push_b;
      end
    end
  end

  // Pointers and occupancy. DEPTH is a power of two so the pointers wrap
  // naturally; count is one bit wider so a full buffer is distinguishable
  // from an empty one. A push of two and a pop in the same cycle nets +1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      tail_ptr <= tail_ptr + PW'(push_num);
      if (pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      count <= count + CW'(push_num) - CW'(pop);
    end
  end

endmodule

// File: rtl/commit_write_scheduler.sv
// ---------------------------------------------------------------------------
// commit_write_scheduler
//
// Purpose: sits between a dual-commit ROB and the register file's single
// commit write port. Up to two in-order commits per cycle are filtered (x0
// writes dropped) and queued, then drained one per cycle into a registered
// set of register-file commit outputs. The drain holds during mispredict
// flush cycles and while rdy is low, because the register file ignores its
// commit inputs then; nothing queued is ever discarded except by reset.
//
// Ports:
//   clk                          clock, all state on rising edge
//   rst                          synchronous active-low reset
//   rdy                          global ready; low freezes everything
//   jump_wrong                   mispredict flush (register file ignores writes)
//   c0_valid/index/rename/value  commit slot 0 (older)
//   c1_valid/index/rename/value  commit slot 1 (younger)
//   commit_ready                 ROB may present commits this cycle
//   rf_enable                    register file rob_enable
//   rf_index                     register file rob_commit_index
//   rf_rename                    register file rob_commit_rename
//   rf_value                     register file rob_commit_value
//   fifo_count                   FIFO occupancy (excludes the presented entry)
// ---------------------------------------------------------------------------

module commit_write_scheduler
  import commit_write_scheduler_pkg::*;
#(
  parameter  int DEPTH = COMMIT_FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             jump_wrong,
  input  logic             c0_valid,
  input  logic [`REGINDEX] c0_index,
  input  logic [`ROBINDEX] c0_rename,
  input  logic [`DATALEN]  c0_value,
  input  logic             c1_valid,
  input  logic [`REGINDEX] c1_index,
  input  logic [`ROBINDEX] c1_rename,
  input  logic [`DATALEN]  c1_value,
  output logic             commit_ready,
  output logic             rf_enable,
  output logic [`REGINDEX] rf_index,
  output logic [`ROBINDEX] rf_rename,
  output logic [`DATALEN]  rf_value,
  output logic [CW-1:0]    fifo_count
);

  // Accept only while at least two slots are free, so a full pair always
  // fits. Deliberately not credited with a same-cycle dequeue.
  localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH - 2);

  commit_entry_t entry0;
  commit_entry_t entry1;
  commit_entry_t push_a;
  commit_entry_t head_entry;
  push_num_e     push_num;
  logic          keep0;
  logic          keep1;
  logic          accept;
  logic          drain;
  logic [CW-1:0] count;

  assign commit_ready = (count <= READY_LIMIT);
  assign fifo_count   = count;

  // Enqueue filter and drain decision. If slot 0 is dropped (invalid or x0)
  // slot 1 moves down to the tail so the buffer stays gap-free. A drain
  // happens whenever the register file is listening (rdy, no flush): the
  // entry currently shown is consumed at this edge, so the next head can be
  // loaded in its place.
  always_comb begin
    entry0   = '{index: c0_index, rename: c0_rename, value: c0_value};
    entry1   = '{index: c1_index, rename: c1_rename, value: c1_value};
    keep0    = slot_kept(c0_valid, c0_index);
    keep1    = slot_kept(c1_valid, c1_index);
    accept   = rdy && commit_ready;
    push_num = accept ? kept_count(keep0, keep1) : PUSH_NONE;
    push_a   = keep0 ? entry0 : entry1;
    drain    = rdy && !jump_wrong && (count != '0);
  end

  commit_fifo #(
    .DEPTH(DEPTH)
  ) u_commit_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_num  (push_num),
    .push_a    (push_a),
    .push_b    (entry1),
    .pop       (drain),
    .head_entry(head_entry),
    .count     (count)
  );

  // Register-file output register. While rdy is low or a flush is in
  // progress the register file is not writing, so the presented entry is
  // held and shown again. Otherwise it counts as written; load the next
  // head or drop rf_enable, keeping the last index/rename/value visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_enable <= `FALSE;
      rf_index  <= ENTRY_RESET.index;
      rf_rename <= ENTRY_RESET.rename;
      rf_value  <= ENTRY_RESET.value;
    end else if (rdy && !jump_wrong) begin
      rf_enable <= drain;
      if (drain) begin
        rf_index  <= head_entry.index;
        rf_rename <= head_entry.rename;
        rf_value  <= head_entry.value;
      end
    end
  end

endmodule

// File: tb/tb_commit_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_commit_write_scheduler
//
// Self-checking bench: a table of directed single-cycle vectors with
// hand-derived expectations, a hand-written pair-streaming sequence, and a
// randomized phase compared against a queue-based reference model.
// ---------------------------------------------------------------------------

`ifndef REGINDEX
`define REGINDEX 4:0
`endif
`ifndef ROBINDEX
`define ROBINDEX 4:0
`endif
`ifndef DATALEN
`define DATALEN 31:0
`endif
`ifndef ROBNOTRENAME
`define ROBNOTRENAME 5'b10000
`endif

module tb_commit_write_scheduler;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NR    = int'(`ROBNOTRENAME);

  typedef struct {
    logic             rst;
    logic             rdy;
    logic             jw;
    logic             c0v;
    logic [`REGINDEX] c0i;
    logic [`ROBINDEX] c0r;
    logic [`DATALEN]  c0d;
    logic             c1v;
    logic [`REGINDEX] c1i;
    logic [`ROBINDEX] c1r;
    logic [`DATALEN]  c1d;
  } stim_t;

  typedef struct {
    stim_t       s;
    int          en;
    int          idx;
    int          ren;
    logic [31:0] val;
    int          cnt;
    int          rdyo;
  } vec_t;

  typedef struct packed {
    logic [`REGINDEX] index;
    logic [`ROBINDEX] rename;
    logic [`DATALEN]  value;
  } tb_entry_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             jump_wrong;
  logic             c0_valid;
  logic [`REGINDEX] c0_index;
  logic [`ROBINDEX] c0_rename;
  logic [`DATALEN]  c0_value;
  logic             c1_valid;
  logic [`REGINDEX] c1_index;
  logic [`ROBINDEX] c1_rename;
  logic [`DATALEN]  c1_value;
  logic             commit_ready;
  logic             rf_enable;
  logic [`REGINDEX] rf_index;
  logic [`ROBINDEX] rf_rename;
  logic [`DATALEN]  rf_value;
  logic [CW-1:0]    fifo_count;

  int checks = 0;
  int errors = 0;

  // Reference model: queued writes in program order plus the presented one
  tb_entry_t mq[$];
  logic      m_en;
  tb_entry_t m_pres;

  vec_t tbl[$];

  always #5 clk = ~clk;

  commit_write_scheduler #(
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .jump_wrong  (jump_wrong),
    .c0_valid    (c0_valid),
    .c0_index    (c0_index),
    .c0_rename   (c0_rename),
    .c0_value    (c0_value),
    .c1_valid    (c1_valid),
    .c1_index    (c1_index),
    .c1_rename   (c1_rename),
    .c1_value    (c1_value),
    .commit_ready(commit_ready),
    .rf_enable   (rf_enable),
    .rf_index    (rf_index),
    .rf_rename   (rf_rename),
    .rf_value    (rf_value),
    .fifo_count  (fifo_count)
  );

  function automatic stim_t mkStim(input int r, input int rd, input int j,
                                   input int v0, input int i0, input int r0, input logic [31:0] d0,
                                   input int v1, input int i1, input int r1, input logic [31:0] d1);
    stim_t s;
    s.rst = (r != 0);
    s.rdy = (rd != 0);
    s.jw  = (j != 0);
    s.c0v = (v0 != 0);
    s.c0i = 5'(i0);
    s.c0r = 5'(r0);
    s.c0d = d0;
    s.c1v = (v1 != 0);
    s.c1i = 5'(i1);
    s.c1r = 5'(r1);
    s.c1d = d1;
    return s;
  endfunction

  function automatic stim_t idleStim();
    return mkStim(1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
  endfunction

  function automatic vec_t mkVec(input stim_t s, input int en, input int idx, input int ren,
                                 input logic [31:0] val, input int cnt, input int rdyo);
    vec_t v;
    v.s    = s;
    v.en   = en;
    v.idx  = idx;
    v.ren  = ren;
    v.val  = val;
    v.cnt  = cnt;
    v.rdyo = rdyo;
    return v;
  endfunction

  // Behavioural rules: reset empties everything; rdy low freezes; when the
  // register file listens the presented write retires and the oldest queued
  // write (if any) is shown next; commits are accepted while two slots are
  // free and x0 writes are discarded.
  task automatic modelStep(input stim_t s);
    bit        room;
    tb_entry_t e;
    if (!s.rst) begin
      mq.delete();
      m_en   = 1'b0;
      m_pres = '{index: '0, rename: `ROBNOTRENAME, value: '0};
    end else if (s.rdy) begin
      room = (mq.size() <= DEPTH - 2);
      if (!s.jw) begin
        if (mq.size() != 0) begin
          m_pres = mq.pop_front();
          m_en   = 1'b1;
        end else begin
          m_en = 1'b0;
        end
      end
      if (room) begin
        if (s.c0v && s.c0i != 0) begin
          e = '{index: s.c0i, rename: s.c0r, value: s.c0d};
          mq.push_back(e);
        end
        if (s.c1v && s.c1i != 0) begin
          e = '{index: s.c1i, rename: s.c1r, value: s.c1d};
          mq.push_back(e);
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1ns after the edge
  task automatic applyStimulus(input stim_t s);
    rst        = s.rst;
    rdy        = s.rdy;
    jump_wrong = s.jw;
    c0_valid   = s.c0v;
    c0_index   = s.c0i;
    c0_rename  = s.c0r;
    c0_value   = s.c0d;
    c1_valid   = s.c1v;
    c1_index   = s.c1i;
    c1_rename  = s.c1r;
    c1_value   = s.c1d;
    modelStep(s);
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string name, input string field,
                            input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %0h, expected %0h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int en, input int idx, input int ren,
                             input logic [31:0] val, input int cnt, input int rdyo);
    checkField(name, "rf_enable", 64'(rf_enable), 64'(en));
    checkField(name, "rf_index", 64'(rf_index), 64'(idx));
    checkField(name, "rf_rename", 64'(rf_rename), 64'(ren));
    checkField(name, "rf_value", 64'(rf_value), 64'(val));
    checkField(name, "fifo_count", 64'(fifo_count), 64'(cnt));
    checkField(name, "commit_ready", 64'(commit_ready), 64'(rdyo));
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, int'(m_en), int'(m_pres.index), int'(m_pres.rename), m_pres.value,
                mq.size(), (mq.size() <= DEPTH - 2) ? 1 : 0);
  endtask

  task automatic runTable();
    stim_t frz;
    frz = mkStim(1, 0, 0, 1, 10, 14, 32'hA0, 0, 0, 0, 32'h0);
    // reset, also with rdy low (reset wins)
    tbl.push_back(mkVec(mkStim(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0), 0, 0, NR, 32'h0, 0, 1));
    tbl.push_back(mkVec(mkStim(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0), 0, 0, NR, 32'h0, 0, 1));
    // single commit into empty FIFO
    tbl.push_back(mkVec(mkStim(1, 1, 0, 1, 5, 3, 32'hDEADBEEF, 0, 0, 0, 32'h0), 0, 0, NR, 32'h0, 1, 1));
    tbl.push_back(mkVec(idleStim(), 1, 5, 3, 32'hDEADBEEF, 0, 1));
    tbl.push_back(mkVec(idleStim(), 0, 5, 3, 32'hDEADBEEF, 0, 1));
    // slot 0 targets x0, only x7 kept
    tbl.push_back(mkVec(mkStim(1, 1, 0, 1, 0, 9, 32'h99, 1, 7, 4, 32'h77), 0, 5, 3, 32'hDEADBEEF, 1, 1));
    tbl.push_back(mkVec(idleStim(), 1, 7, 4, 32'h77, 0, 1));
    tbl.push_back(mkVec(idleStim(), 0, 7, 4, 32'h77, 0, 1));
    // slot 1 alone
    tbl.push_back(mkVec(mkStim(1, 1, 0, 0, 0, 0, 32'h0, 1, 9, 6, 32'h1234), 0, 7, 4, 32'h77, 1, 1));
    tbl.push_back(mkVec(idleStim(), 1, 9, 6, 32'h1234, 0, 1));
    // presented entry held across two flush cycles
    tbl.push_back(mkVec(mkStim(1, 1, 0, 1, 1, 1, 32'h11, 1, 2, 2, 32'h22), 0, 9, 6, 32'h1234, 2, 1));
    tbl.push_back(mkVec(idleStim(), 1, 1, 1, 32'h11, 1, 1));
    tbl.push_back(mkVec(mkStim(1, 1, 1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0), 1, 1, 1, 32'h11, 1, 1));
    tbl.push_back(mkVec(mkStim(1, 1, 1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0), 1, 1, 1, 32'h11, 1, 1));
    tbl.push_back(mkVec(idleStim(), 1, 2, 2, 32'h22, 0, 1));
    tbl.push_back(mkVec(idleStim(), 0, 2, 2, 32'h22, 0, 1));
    // rdy low for three cycles with entries queued
    tbl.push_back(mkVec(mkStim(1, 1, 0, 1, 3, 5, 32'h33, 1, 4, 7, 32'h44), 0, 2, 2, 32'h22, 2, 1));
    tbl.push_back(mkVec(idleStim(), 1, 3, 5, 32'h33, 1, 1));
    tbl.push_back(mkVec(frz, 1, 3, 5, 32'h33, 1, 1));
    tbl.push_back(mkVec(frz, 1, 3, 5, 32'h33, 1, 1));
    tbl.push_back(mkVec(frz, 1, 3, 5, 32'h33, 1, 1));
    tbl.push_back(mkVec(idleStim(), 1, 4, 7, 32'h44, 0, 1));
    tbl.push_back(mkVec(idleStim(), 0, 4, 7, 32'h44, 0, 1));
    // build up three entries, then reset mid-operation
    tbl.push_back(mkVec(mkStim(1, 1, 0, 1, 11, 8, 32'hAA, 1, 12, 9, 32'hBB), 0, 4, 7, 32'h44, 2, 1));
    tbl.push_back(mkVec(mkStim(1, 1, 0, 1, 13, 10, 32'hCC, 0, 0, 0, 32'h0), 1, 11, 8, 32'hAA, 2, 1));
    tbl.push_back(mkVec(mkStim(1, 1, 0, 1, 14, 11, 32'hDD, 0, 0, 0, 32'h0), 1, 12, 9, 32'hBB, 2, 1));
    tbl.push_back(mkVec(mkStim(1, 1, 0, 1, 15, 12, 32'hEE, 1, 16, 13, 32'hFF), 1, 13, 10, 32'hCC, 3, 0));
    tbl.push_back(mkVec(mkStim(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0), 0, 0, NR, 32'h0, 0, 1));
    tbl.push_back(mkVec(idleStim(), 0, 0, NR, 32'h0, 0, 1));
    // enqueue still accepted during a flush cycle
    tbl.push_back(mkVec(mkStim(1, 1, 1, 1, 20, 15, 32'h2020, 0, 0, 0, 32'h0), 0, 0, NR, 32'h0, 1, 1));
    tbl.push_back(mkVec(idleStim(), 1, 20, 15, 32'h2020, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].s);
      checkOutput($sformatf("vec%0d", i), tbl[i].en, tbl[i].idx, tbl[i].ren,
                  tbl[i].val, tbl[i].cnt, tbl[i].rdyo);
    end
  endtask

  // Pair {x1},{x2} offered for 8 cycles whenever the scheduler has room;
  // five pairs fit, so exactly ten writes must alternate x1,x2.
  task automatic runPairSequence();
    int    obs[$];
    bit    saw_low;
    int    max_cnt;
    stim_t pair;
    pair    = mkStim(1, 1, 0, 1, 1, 1, 32'h11, 1, 2, 2, 32'h22);
    saw_low = 1'b0;
    max_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8 && mq.size() <= DEPTH - 2) applyStimulus(pair);
      else applyStimulus(idleStim());
      if (rf_enable) obs.push_back(int'(rf_index));
      if (!commit_ready) saw_low = 1'b1;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      checkModel("pair");
    end
    checkField("pair", "write_count", 64'(obs.size()), 64'(10));
    checkField("pair", "ready_dropped", 64'(saw_low), 64'(1));
    checkField("pair", "peak_count", 64'(max_cnt), 64'(3));
    for (int i = 0; i < obs.size() && i < 10; i++) begin
      checkField($sformatf("pair_order%0d", i), "rf_index", 64'(obs[i]), 64'((i % 2 == 0) ? 1 : 2));
    end
  endtask

  task automatic runRandom();
    stim_t s;
    applyStimulus(mkStim(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    checkModel("rand_reset");
    for (int c = 0; c < 3000; c++) begin
      s     = idleStim();
      s.rst = ($urandom_range(0, 99) != 0);
      s.rdy = ($urandom_range(0, 9) >= 2);
      s.jw  = ($urandom_range(0, 9) < 2);
      if (mq.size() <= DEPTH - 2) begin
        s.c0v = ($urandom_range(0, 2) != 0);
        s.c1v = ($urandom_range(0, 2) != 0);
      end
      s.c0i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.c1i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.c0r = 5'($urandom_range(0, 31));
      s.c1r = 5'($urandom_range(0, 31));
      s.c0d = $urandom;
      s.c1d = $urandom;
      applyStimulus(s);
      checkModel($sformatf("rand%0d", c));
    end
  endtask

  initial begin
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    runTable();
    runPairSequence();
    runRandom();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
